// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pong_pkg
// Brief  : Shared game-state encoding and constants for the pong controller.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pong_pkg;

  // Game-state encoding, also driven directly onto the game_state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  // Score ceiling as two BCD digits.
  localparam logic [7:0] BCD_MAX = 8'h99;

  // Width of the lives counter.
  localparam int LIVES_W = 2;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_edge_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pong_edge_det
// Brief  : Rising-edge detector with an optional synchroniser in front.
//          SYNC_STAGES = 0 uses the input as-is (already clk-synchronous);
//          SYNC_STAGES > 0 passes it through that many flops first.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pong_edge_det #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);
  import pong_pkg::*;

  logic sig_s;
  logic prev_q;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sig_s = sig_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw input through the synchroniser chain.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_i);
        end
      end

      assign sig_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_s;
    end
  end

  assign pulse_o = sig_s & ~prev_q;

endmodule : pong_edge_det
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pong_game_ctrl
// Brief  : Pong game sequencer. Owns the IDLE/SERVE/PLAY/OVER state machine,
//          BCD score, lives, and the ball run/recentre controls.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int LIVES              = 3,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int OVER_DELAY_FRAMES  = 120,
  parameter int FRAME_CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic                      btn_start,
  input  logic                      ball_hit,
  input  logic                      ball_miss,
  output logic                      ball_run,
  output logic                      ball_reset,
  output logic [7:0]                score,
  output logic [pong_pkg::LIVES_W-1:0] lives,
  output logic [1:0]                game_state
);
  import pong_pkg::*;

  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = FRAME_CNT_W'(OVER_DELAY_FRAMES - 1);
  localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);

  game_state_e            state_q, state_d;
  logic [7:0]             score_q, score_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   ball_reset_q, ball_reset_d;
  logic                   ball_run_q;
  logic                   frame_tick;
  logic                   start_evt;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v >= BCD_MAX) begin
      r = BCD_MAX;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // vsync is already clk-synchronous: edge detect only.
  pong_edge_det #(.SYNC_STAGES(0)) u_vsync_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (vsync),
    .pulse_o (frame_tick)
  );

  // The button is asynchronous: synchronise, then edge detect.
  pong_edge_det #(.SYNC_STAGES(2)) u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (btn_start),
    .pulse_o (start_evt)
  );

  // State, score, lives, frame counter and ball control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      score_q      <= 8'h00;
      lives_q      <= '0;
      cnt_q        <= '0;
      ball_reset_q <= 1'b0;
      ball_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      ball_reset_q <= ball_reset_d;
      // Follows the current state, so it lags PLAY entry and exit by one clk.
      ball_run_q   <= (state_q == PLAY);
    end
  end

  // Next-state logic; score and lives hold unless a game event changes them.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    ball_reset_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_evt) begin
          score_d      = 8'h00;
          lives_d      = LIVES_INIT;
          cnt_d        = '0;
          ball_reset_d = 1'b1;
          state_d      = SERVE;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      PLAY: begin
        // A miss takes priority over a coincident hit.
        if (ball_miss) begin
          cnt_d = '0;
          if (lives_q > LIVES_W'(1)) begin
            lives_d      = lives_q - 1'b1;
            ball_reset_d = 1'b1;
            state_d      = SERVE;
          end else begin
            lives_d = '0;
            state_d = OVER;
          end
        end else if (ball_hit) begin
          score_d = bcd_inc(score_q);
        end
      end

      OVER: begin
        if (frame_tick) begin
          if (cnt_q == OVER_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_pong_game_ctrl
// Brief  : Directed self-checking bench for pong_game_ctrl.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       btn_start;
  logic       ball_hit;
  logic       ball_miss;
  logic       ball_run;
  logic       ball_reset;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_errors = 0;

  pong_game_ctrl #(
    .LIVES              (3),
    .SERVE_DELAY_FRAMES (60),
    .OVER_DELAY_FRAMES  (120),
    .FRAME_CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .btn_start  (btn_start),
    .ball_hit   (ball_hit),
    .ball_miss  (ball_miss),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .score      (score),
    .lives      (lives),
    .game_state (game_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync frame: one clk high, one clk low.
  task automatic frame();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      ball_hit = 1'b1;
      step();
      ball_hit = 1'b0;
    end
  endtask

  // Full serve: 60 frames, then one idle clk so ball_run is up.
  task automatic serve();
    frames(60);
  endtask

  initial begin
    reset     = 1'b1;
    vsync     = 1'b0;
    btn_start = 1'b0;
    ball_hit  = 1'b0;
    ball_miss = 1'b0;
    step();
    step();
    check("rst_state", game_state, 2'd0);
    check("rst_score", score, 8'h00);
    check("rst_lives", lives, 2'd0);
    check("rst_run", ball_run, 1'b0);
    check("rst_breset", ball_reset, 1'b0);
    reset = 1'b0;
    step();

    // Start button: event after three edges.
    btn_start = 1'b1;
    step();
    step();
    check("start_lat2_state", game_state, 2'd0);
    step();
    check("start_state", game_state, 2'd1);
    check("start_lives", lives, 2'd3);
    check("start_score", score, 8'h00);
    check("start_breset", ball_reset, 1'b1);
    step();
    check("start_breset_once", ball_reset, 1'b0);
    btn_start = 1'b0;

    // Hits during SERVE are ignored.
    hits(1);
    check("serve_hit_ign", score, 8'h00);

    // Serve delay: 59 frames stay in SERVE, 60th enters PLAY.
    frames(59);
    check("serve59_state", game_state, 2'd1);
    vsync = 1'b1;
    step();
    check("serve60_state", game_state, 2'd2);
    check("serve60_run_lag", ball_run, 1'b0);
    vsync = 1'b0;
    step();
    check("play_run", ball_run, 1'b1);

    // BCD score increments.
    hits(9);
    check("score_09", score, 8'h09);
    hits(1);
    check("score_10", score, 8'h10);

    // Plain miss with lives 3.
    ball_miss = 1'b1;
    step();
    ball_miss = 1'b0;
    check("miss3_lives", lives, 2'd2);
    check("miss3_state", game_state, 2'd1);
    check("miss3_breset", ball_reset, 1'b1);
    check("miss3_run_lag", ball_run, 1'b1);
    step();
    check("miss3_run_off", ball_run, 1'b0);
    check("miss3_breset_once", ball_reset, 1'b0);
    serve();
    check("reserve1_state", game_state, 2'd2);

    // Simultaneous hit and miss: miss wins, score unchanged.
    ball_hit  = 1'b1;
    ball_miss = 1'b1;
    step();
    ball_hit  = 1'b0;
    ball_miss = 1'b0;
    check("hm_lives", lives, 2'd1);
    check("hm_score", score, 8'h10);
    check("hm_state", game_state, 2'd1);
    check("hm_breset", ball_reset, 1'b1);
    step();
    check("hm_breset_once", ball_reset, 1'b0);
    serve();
    check("reserve2_state", game_state, 2'd2);

    // Fill to 99, then saturate.
    hits(89);
    check("score_99", score, 8'h99);
    hits(1);
    check("score_sat", score, 8'h99);

    // Final miss: OVER, no recentre.
    ball_miss = 1'b1;
    step();
    ball_miss = 1'b0;
    check("over_lives", lives, 2'd0);
    check("over_state", game_state, 2'd3);
    check("over_breset", ball_reset, 1'b0);

    // Start during OVER ignored.
    btn_start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("over_btn_state", game_state, 2'd3);
    check("over_btn_lives", lives, 2'd0);
    frames(119);
    check("over119_state", game_state, 2'd3);
    frames(1);
    check("over120_state", game_state, 2'd0);
    check("idle_score_kept", score, 8'h99);
    for (int i = 0; i < 4; i++) step();
    check("idle_no_queued", game_state, 2'd0);
    btn_start = 1'b0;
    step();
    step();
    step();

    // New game, score to 42, then reset mid-PLAY.
    btn_start = 1'b1;
    step();
    step();
    step();
    check("restart_state", game_state, 2'd1);
    check("restart_score", score, 8'h00);
    btn_start = 1'b0;
    serve();
    hits(42);
    check("score_42", score, 8'h42);
    check("pre_rst_run", ball_run, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_score", score, 8'h00);
    check("arst_lives", lives, 2'd0);
    check("arst_run", ball_run, 1'b0);
    check("arst_state", game_state, 2'd0);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pong_game_ctrl
`default_nettype wire
